// File: rtl/cmd_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_slot_arbiter
//  Purpose  : Two-requester arbiter feeding the registered DDR5 command slot.
//             Batches commands from one source, inserts a turnaround bubble
//             on source switch, and force-switches a starved requester.
//  Options  : ARB_STATS_EN adds grant_cnt_a / grant_cnt_b / switch_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_slot_arbiter #(
    parameter int CMD_W        = 32,
    parameter int TA_CYCLES    = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [CMD_W-1:0] a_cmd,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [CMD_W-1:0] b_cmd,
    output logic             b_ready,
    output logic             out_valid,
    output logic [CMD_W-1:0] out_cmd,
    output logic             out_src,
    input  logic             stall,
    output logic             cong
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]      grant_cnt_a,
    output logic [15:0]      grant_cnt_b,
    output logic [15:0]      switch_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // The decision cycle is itself the first bubble cycle, so TURN covers the rest.
    localparam logic [CNT_W-1:0] C_TA_REM  = CNT_W'((TA_CYCLES > 0) ? (TA_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] C_STARVE  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic               cur_src_q, cur_src_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [CNT_W-1:0]   ta_cnt_q, ta_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [CMD_W-1:0]   out_cmd_q, out_cmd_d;
    logic               out_src_q, out_src_d;

    logic w_slot_free, w_owner_valid, w_other_valid, w_want_switch;
    logic w_a_grant, w_b_grant, w_switch_evt, w_a_xfer, w_b_xfer;

    assign w_slot_free   = !out_valid_q || !stall;
    assign w_owner_valid = cur_src_q ? b_valid : a_valid;
    assign w_other_valid = cur_src_q ? a_valid : b_valid;
    assign w_want_switch = w_other_valid && (!w_owner_valid || (starve_cnt_q >= C_STARVE));

    // Arbitration FSM: next state, counters and grants.
    always_comb begin
        state_d      = state_q;
        cur_src_d    = cur_src_q;
        starve_cnt_d = starve_cnt_q;
        ta_cnt_d     = ta_cnt_q;
        w_a_grant    = 1'b0;
        w_b_grant    = 1'b0;
        w_switch_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_slot_free && (a_valid || b_valid)) begin
                    state_d   = ST_SERVE;
                    cur_src_d = !a_valid;
                    w_a_grant = a_valid;
                    w_b_grant = !a_valid;
                end
            end
            ST_SERVE: begin
                if (w_other_valid) begin
                    starve_cnt_d = (starve_cnt_q != C_CNT_MAX) ? starve_cnt_q + 1'b1 : starve_cnt_q;
                end else begin
                    starve_cnt_d = '0;
                end
                if (w_want_switch && w_slot_free) begin
                    w_switch_evt = 1'b1;
                    starve_cnt_d = '0;
                    if (TA_CYCLES == 0) begin
                        // Hand over immediately: the new owner is granted this cycle.
                        cur_src_d = !cur_src_q;
                        w_a_grant = cur_src_q;
                        w_b_grant = !cur_src_q;
                    end else if (TA_CYCLES == 1) begin
                        cur_src_d = !cur_src_q;
                    end else begin
                        state_d  = ST_TURN;
                        ta_cnt_d = C_TA_REM;
                    end
                end else if (w_slot_free && !w_want_switch) begin
                    w_a_grant = !cur_src_q;
                    w_b_grant = cur_src_q;
                end
            end
            ST_TURN: begin
                if (ta_cnt_q <= 1) begin
                    ta_cnt_d  = '0;
                    cur_src_d = !cur_src_q;
                    state_d   = ST_SERVE;
                end else begin
                    ta_cnt_d = ta_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign a_ready  = w_a_grant && !rst;
    assign b_ready  = w_b_grant && !rst;
    assign w_a_xfer = a_valid && a_ready;
    assign w_b_xfer = b_valid && b_ready;

    // Command slot: load on transfer, hold while stalled, empty when drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_cmd_d   = out_cmd_q;
        out_src_d   = out_src_q;
        if (w_a_xfer) begin
            out_valid_d = 1'b1;
            out_cmd_d   = a_cmd;
            out_src_d   = 1'b0;
        end else if (w_b_xfer) begin
            out_valid_d = 1'b1;
            out_cmd_d   = b_cmd;
            out_src_d   = 1'b1;
        end else if (w_slot_free) begin
            out_valid_d = 1'b0;
        end
    end

    // State and slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_src_q    <= 1'b0;
            starve_cnt_q <= '0;
            ta_cnt_q     <= '0;
            out_valid_q  <= 1'b0;
            out_cmd_q    <= '0;
            out_src_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_src_q    <= cur_src_d;
            starve_cnt_q <= starve_cnt_d;
            ta_cnt_q     <= ta_cnt_d;
            out_valid_q  <= out_valid_d;
            out_cmd_q    <= out_cmd_d;
            out_src_q    <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_cmd   = out_cmd_q;
    assign out_src   = out_src_q;
    assign cong      = out_valid_q && stall;

`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt_a_q, grant_cnt_a_d;
    logic [15:0] grant_cnt_b_q, grant_cnt_b_d;
    logic [15:0] switch_cnt_q, switch_cnt_d;

    // Statistics counters, wrapping modulo 2^16.
    always_comb begin
        grant_cnt_a_d = grant_cnt_a_q + {15'd0, w_a_xfer};
        grant_cnt_b_d = grant_cnt_b_q + {15'd0, w_b_xfer};
        switch_cnt_d  = switch_cnt_q + {15'd0, w_switch_evt};
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_a_q <= '0;
            grant_cnt_b_q <= '0;
            switch_cnt_q  <= '0;
        end else begin
            grant_cnt_a_q <= grant_cnt_a_d;
            grant_cnt_b_q <= grant_cnt_b_d;
            switch_cnt_q  <= switch_cnt_d;
        end
    end

    assign grant_cnt_a = grant_cnt_a_q;
    assign grant_cnt_b = grant_cnt_b_q;
    assign switch_cnt  = switch_cnt_q;
`else
    logic w_unused_switch;
    assign w_unused_switch = w_switch_evt;
`endif

endmodule
`default_nettype wire

// File: doc/cmd_slot_arbiter.md
Name: cmd_slot_arbiter

Overview:
- Two-requester arbiter/scheduler for the DDR5 controller's registered command slot. The slot is a muxed DFF stage with a congestion flag.
- Selects between requester A (read queue) and requester B (write queue) with valid/ready handshakes.
- Batches consecutive commands from one source, inserts a programmable turnaround bubble on source switch, and force-switches on starvation.
- Holds the issued command stable while the downstream stage stalls.

Parameters:
- CMD_W, 32, width of command word.
- TA_CYCLES, 2, bubble cycles inserted on every A<->B switch (0 = switch with no bubble).
- STARVE_LIMIT, 8, waiting cycles of the non-granted source that force a switch.
- CNT_W, 4, width of starvation and turnaround counters; must hold max(TA_CYCLES, STARVE_LIMIT).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- a_valid  in  1  requester A has a command.
- a_cmd  in  CMD_W  requester A command.
- a_ready  out  1  slot accepts A this cycle.
- b_valid  in  1  requester B has a command.
- b_cmd  in  CMD_W  requester B command.
- b_ready  out  1  slot accepts B this cycle.
- out_valid  out  1  slot holds a command.
- out_cmd  out  CMD_W  issued command.
- out_src  out  1  0 = from A, 1 = from B.
- stall  in  1  downstream cannot take out_cmd this cycle.
- cong  out  1  congestion flag = out_valid & stall (combinational).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, cur_src=0, counters=0, out_valid=0, out_cmd=0, out_src=0. a_ready and b_ready are 0 during the reset cycle. Reset mid-operation drops any held command without issuing it.
- slot_free = !out_valid | !stall (slot is empty or being drained this cycle).
- Transfer: x_valid & x_ready at the edge. out_cmd and out_src are loaded and out_valid=1 on the next cycle, i.e. 1-cycle latency.
- If slot_free and no transfer, out_valid clears. While stall=1 and out_valid=1, out_cmd and out_src are held bit-stable.
- Ready signals are combinational from state, slot_free and valids; a_ready and b_ready are never both 1.
- State IDLE:
  - No source is owned.
  - If slot_free and any valid: grant A if a_valid, else B (A wins ties). Ready is asserted the same cycle, then go to SERVE with cur_src set to the granted source.
- State SERVE (owner = cur_src):
  - owner_ready = slot_free & !want_switch.
  - want_switch = other_valid & (!owner_valid | starve_cnt >= STARVE_LIMIT).
  - If want_switch and slot_free:
    - TA_CYCLES=0: flip cur_src and grant the new owner in the same cycle.
    - Otherwise: go to TURN with ta_cnt=TA_CYCLES-1; both readies are 0 this cycle.
  - If neither valid, stay in SERVE; ownership is retained.
- State TURN:
  - Both readies are 0. ta_cnt decrements each cycle.
  - On ta_cnt==0, flip cur_src and go to SERVE.
  - Exactly TA_CYCLES consecutive no-ready cycles occur between the switch decision and the new owner's first ready.
  - Requesters dropping valid during TURN does not abort the switch.
- starve_cnt:
  - Increments, saturating at 2^CNT_W-1, each cycle the non-owner has valid=1 while in SERVE.
  - Clears on a switch and when the non-owner's valid is 0.
  - Does not count during TURN or IDLE.
- out_valid=1 persisting across a switch is allowed: the turnaround counts from the decision cycle, not from slot drain.
- cong is unaffected by arbitration state.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs grant_cnt_a, grant_cnt_b (16 bits each) counting transfers per source and switch_cnt (16 bits) counting switch decisions.
  - All three wrap modulo 2^16 and reset to 0 on rst.
- Not defined: those ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- rst=1 for 2 cycles with a_valid=b_valid=1 -> out_valid=0, a_ready=b_ready=0. First cycle after release: a_ready=1, b_ready=0.
- A only, 4 commands 0x10..0x13 back-to-back, stall=0 -> out_cmd=0x10..0x13 on consecutive cycles, each 1 cycle after its accept, out_src=0.
- A streaming, B asserts valid at cycle 5, STARVE_LIMIT=8, TA_CYCLES=2 -> B unserved for 8 counted cycles, then 2 cycles with both readies low, then b_ready=1. out_src=1 on the next issue.
- A stops while B valid, TA_CYCLES=0 -> b_ready=1 in the first cycle a_valid=0 with slot_free; no bubble.
- out_valid=1 with cmd 0xAB, stall held 3 cycles -> out_cmd=0xAB stable, cong=1 for 3 cycles, a_ready=0. Drain cycle: cong=0 and the next command is accepted.
- rst pulsed while in TURN with out_valid=1 -> next cycle out_valid=0, state IDLE, A wins a simultaneous request.
